// File: rtl/instr_display_writer_pkg.sv
// ---------------------------------------------------------------------------
// instr_display_writer_pkg
//   Shared constants for the instruction/result display writer:
//   FSM state encodings, display page type, seven-segment glyphs and a
//   small nibble bit-reverse helper used for the LEDR mirror.
// ---------------------------------------------------------------------------
package instr_display_writer_pkg;

    // Writer FSM states
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_BLINK  = 2'd1;
    localparam logic [1:0] ST_STEADY = 2'd2;

    // Which page the HEX displays show
    typedef enum logic {
        PAGE_INSTR  = 1'b0,
        PAGE_RESULT = 1'b1
    } page_e;

    // Active-low glyphs, bit 0 = segment a
    localparam logic [6:0] BLANK   = 7'h7F;
    localparam logic [6:0] GLYPH_I = 7'b1111001;
    localparam logic [6:0] GLYPH_R = 7'b0101111;

    // The switch bank is wired MSB-on-the-right, so each field is mirrored.
    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/instr_display_writer_hex.sv
// ---------------------------------------------------------------------------
// hex_to_7seg
//   Combinational hex digit to seven-segment decoder.
//   Ports:
//     nibble_i  in  4  value 0-F
//     seg_o     out 7  active-low segments, bit 0 = a .. bit 6 = g
// ---------------------------------------------------------------------------
module hex_to_7seg
    import instr_display_writer_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = BLANK;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = BLANK;
        endcase
    end

endmodule

// File: rtl/instr_display_writer.sv
// ---------------------------------------------------------------------------
// instr_display_writer
//   Holds a captured instruction word and a CPU result and drives the DE2
//   seven-segment displays and LEDs. Each instruction load triggers a timed
//   blink of HEX4..HEX0; a KEY press flips between instruction and result
//   pages once the blink has finished.
//
//   Handshake: a load is taken on any rising edge where load_valid and
//   load_ready are both high; load_ready is low only while blinking, and a
//   load_valid seen then is dropped, not held over.
//
//   Ports:
//     CLOCK_50      in   1   system clock
//     reset         in   1   synchronous active-high reset
//     load_valid    in   1   instruction fields valid
//     load_ready    out  1   ready to accept a load
//     codop/addA/addB_LMM/addC  in 4 each  instruction fields
//     result_valid  in   1   one-cycle result strobe
//     result        in  16   CPU result
//     page_key      in   1   raw active-low KEY (asynchronous)
//     HEX0..HEX7    out  7   active-low segment drives
//     LEDR          out 18   bit-reversed instruction mirror
//     LEDG          out  8   [0] result fresh, [1] blinking, [7] result page
// ---------------------------------------------------------------------------
module instr_display_writer
    import instr_display_writer_pkg::*;
#(
    parameter int BLINK_DIV   = 25000000,
    parameter int BLINK_COUNT = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [3:0]  codop,
    input  logic [3:0]  addA,
    input  logic [3:0]  addB_LMM,
    input  logic [3:0]  addC,
    input  logic        result_valid,
    input  logic [15:0] result,
    input  logic        page_key,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7,
    output logic [17:0] LEDR,
    output logic [7:0]  LEDG
);

    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW = $clog2(2 * BLINK_COUNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TOG_LAST   = TW'(2 * BLINK_COUNT);

    // Control / data state
    logic [1:0]    state_q, state_d;
    page_e         page_q, page_d;
    logic [3:0]    codop_q, codop_d, adda_q, adda_d, addb_q, addb_d, addc_q, addc_d;
    logic [15:0]   result_q, result_d;
    logic          fresh_q, fresh_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tog_q, tog_d;
    logic          phase_on_q, phase_on_d;

    // Key synchronizer; key_prev_q holds the last synchronized level
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_prev_q;
    logic                   key_sync;
    logic                   key_fall;

    // Registered outputs
    logic [6:0]  hex_q [8];
    logic [6:0]  hex_d [8];
    logic [17:0] ledr_q, ledr_d;
    logic [7:0]  ledg_q, ledg_d;

    logic        load_accept;
    logic [6:0]  seg [4];
    logic [3:0]  nib [4];

    assign key_sync    = sync_q[SYNC_STAGES-1];
    assign key_fall    = key_prev_q & ~key_sync;
    assign load_ready  = (state_q != ST_BLINK);
    assign load_accept = load_valid & load_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        codop_d    = codop_q;
        adda_d     = adda_q;
        addb_d     = addb_q;
        addc_d     = addc_q;
        result_d   = result_q;
        fresh_d    = fresh_q;
        presc_d    = presc_q;
        tog_d      = tog_q;
        phase_on_d = phase_on_q;

        case (state_q)
            ST_BLINK: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d    = '0;
                    phase_on_d = ~phase_on_q;
                    tog_d      = tog_q + 1'b1;
                    if (tog_q + 1'b1 == TOG_LAST) begin
                        state_d    = ST_STEADY;
                        phase_on_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_STEADY: begin
                // A same-edge load wins: it forces the INSTR page anyway.
                if (key_fall && !load_accept) begin
                    if (page_q == PAGE_INSTR) begin
                        page_d  = PAGE_RESULT;
                        fresh_d = 1'b0;
                    end else begin
                        page_d = PAGE_INSTR;
                    end
                end
            end
            default: ;
        endcase

        if (load_accept) begin
            codop_d    = codop;
            adda_d     = addA;
            addb_d     = addB_LMM;
            addc_d     = addC;
            state_d    = ST_BLINK;
            page_d     = PAGE_INSTR;
            presc_d    = '0;
            tog_d      = '0;
            phase_on_d = 1'b1;
        end

        // Placed last so a new result stays fresh even on a page-flip edge.
        if (result_valid) begin
            result_d = result;
            fresh_d  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display decode, from the current registered state
    // ------------------------------------------------------------------
    always_comb begin
        if (page_q == PAGE_RESULT) begin
            nib[3] = result_q[15:12];
            nib[2] = result_q[11:8];
            nib[1] = result_q[7:4];
            nib[0] = result_q[3:0];
        end else begin
            nib[3] = codop_q;
            nib[2] = adda_q;
            nib[1] = addb_q;
            nib[0] = addc_q;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dec
        hex_to_7seg u_dec (
            .nibble_i (nib[g]),
            .seg_o    (seg[g])
        );
    end

    always_comb begin
        for (int i = 0; i < 8; i++) hex_d[i] = BLANK;
        ledr_d = '0;
        ledg_d = '0;

        if (state_q != ST_EMPTY) begin
            ledr_d = {2'b00, rev4(codop_q), rev4(adda_q), rev4(addb_q), rev4(addc_q)};
            if (state_q != ST_BLINK || phase_on_q) begin
                for (int i = 0; i < 4; i++) hex_d[i] = seg[i];
                hex_d[4] = (page_q == PAGE_RESULT) ? GLYPH_R : GLYPH_I;
            end
        end

        ledg_d[0] = fresh_q;
        ledg_d[1] = (state_q == ST_BLINK);
        ledg_d[7] = (page_q == PAGE_RESULT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            page_q     <= PAGE_INSTR;
            codop_q    <= '0;
            adda_q     <= '0;
            addb_q     <= '0;
            addc_q     <= '0;
            result_q   <= '0;
            fresh_q    <= 1'b0;
            presc_q    <= '0;
            tog_q      <= '0;
            phase_on_q <= 1'b1;
            sync_q     <= '1;
            key_prev_q <= 1'b1;
            for (int i = 0; i < 8; i++) hex_q[i] <= BLANK;
            ledr_q     <= '0;
            ledg_q     <= '0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            codop_q    <= codop_d;
            adda_q     <= adda_d;
            addb_q     <= addb_d;
            addc_q     <= addc_d;
            result_q   <= result_d;
            fresh_q    <= fresh_d;
            presc_q    <= presc_d;
            tog_q      <= tog_d;
            phase_on_q <= phase_on_d;
            for (int i = SYNC_STAGES - 1; i > 0; i--) sync_q[i] <= sync_q[i-1];
            sync_q[0]  <= page_key;
            key_prev_q <= key_sync;
            for (int i = 0; i < 8; i++) hex_q[i] <= hex_d[i];
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign HEX6 = hex_q[6];
    assign HEX7 = hex_q[7];
    assign LEDR = ledr_q;
    assign LEDG = ledg_q;

endmodule

// File: doc/instr_display_writer.md
Name: instr_display_writer

Overview:
- Output-side counterpart of the switch/KEY instruction capture path on the DE2 board.
- Accepts a captured instruction word (codop, addA, addB_LMM, addC) and a 16-bit CPU result, holds them, and writes them to the seven-segment displays and LEDs.
- Shows a timed blink acknowledgement after each instruction load.
- A debounced-free, synchronized KEY press switches the display between the instruction page and the result page.

Parameters:
- BLINK_DIV, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz).
- BLINK_COUNT, 3, number of full on/off blink periods after a load.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous page_key input.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  instruction fields are valid.
- load_ready  out  1  block can accept a load.
- codop  in  4  opcode field.
- addA  in  4  operand A address.
- addB_LMM  in  4  operand B address or immediate.
- addC  in  4  destination address.
- result_valid  in  1  result strobe, one cycle.
- result  in  16  CPU result value.
- page_key  in  1  raw board KEY, active-low, asynchronous.
- HEX0..HEX7  out  7 each  segment drives, active-low, bit 0 = segment a.
- LEDR  out  18  instruction mirror.
- LEDG  out  8  status.

Behaviour:
- Reset:
  - HEX0..HEX7 = 7'h7F (blank); LEDR = 0; LEDG = 0; load_ready = 1.
  - State = EMPTY, page = INSTR; stored fields = 0; stored result = 0.
  - Blink counters = 0; synchronizer flops = 1.
- Reset mid-blink or mid-key-press returns to the reset state on the next edge.
- All outputs are registered: one cycle of latency from any state, page or data change to HEX/LEDR/LEDG.
- Load handshake:
  - A load is accepted on an edge where load_valid & load_ready.
  - All four fields are captured on that edge.
  - State becomes BLINK; page is forced to INSTR; prescaler and toggle count are cleared; blink phase = ON.
- load_ready = 0 while in BLINK, 1 in EMPTY and STEADY. A load_valid asserted while in BLINK is ignored with no effect.
- FSM:
  - EMPTY -> BLINK on an accepted load.
  - BLINK -> STEADY after 2*BLINK_COUNT phase toggles.
  - STEADY -> BLINK on an accepted load.
  - No other transitions.
- Blink:
  - The prescaler counts 0..BLINK_DIV-1.
  - At terminal count it wraps to 0, the phase toggles, and the toggle count increments.
  - On the edge where the toggle count reaches 2*BLINK_COUNT, state becomes STEADY with phase ON.
  - The prescaler is idle (held at 0) outside BLINK.
- Result path:
  - result_valid captures result in any state, including EMPTY and BLINK, and sets LEDG[0] (fresh).
  - LEDG[0] clears when the page changes to RESULT.
- Simultaneous load and result_valid: both are captured on the same edge.
- Page key:
  - page_key passes through SYNC_STAGES flops.
  - A falling edge of the synchronized signal (1 -> 0) toggles page, only in STEADY.
  - In EMPTY and BLINK the edge is discarded and not queued.
  - Holding the key produces a single toggle.
- Display, EMPTY: all HEX blank.
- Display, BLINK with phase OFF: HEX0..HEX4 blank.
- Display, otherwise:
  - INSTR page: HEX3 = codop, HEX2 = addA, HEX1 = addB_LMM, HEX0 = addC, as hex glyphs 0-F. HEX4 = glyph 'I' (7'b1111001).
  - RESULT page: HEX3..HEX0 = result[15:12], [11:8], [7:4], [3:0]. HEX4 = glyph 'r' (7'b0101111).
  - HEX7..HEX5 are always blank.
- LEDR mirrors the switch layout, with each field bit-reversed:
  - LEDR[15:12] = {codop[0],codop[1],codop[2],codop[3]}.
  - LEDR[11:8] = addA reversed; LEDR[7:4] = addB_LMM reversed; LEDR[3:0] = addC reversed.
  - LEDR[17:16] = 0.
  - LEDR is updated on load, including in BLINK; it does not blink; it is 0 in EMPTY.
- LEDG: LEDG[0] = result fresh; LEDG[1] = state is BLINK; LEDG[7] = page is RESULT; the other bits are 0.

Decomposition:
- Shared package:
  - State enum: EMPTY, BLINK, STEADY.
  - Page enum: INSTR, RESULT.
  - Glyph constants: BLANK = 7'h7F, GLYPH_I, GLYPH_R.
- Sub-module hex_to_7seg: combinational, 4-bit in, 7-bit active-low out; instantiated four times (HEX3..HEX0).
- The FSM, counters and synchronizer stay in the top module.

Test Plan:
- Bench parameters: BLINK_DIV = 4, BLINK_COUNT = 2.
- Reset: assert reset for 2 cycles -> HEX0..HEX7 = 7'h7F, LEDR = 0, LEDG = 0, load_ready = 1.
- Load: codop = A, addA = 3, addB_LMM = C, addC = 5 with load_valid for 1 cycle.
  - load_ready = 0 on the next cycle.
  - HEX3..HEX0 show A,3,C,5 and blank alternately every 4 cycles.
  - STEADY and load_ready = 1 after 16 cycles.
  - LEDR = 18'h05C3A; LEDG[1] = 1 throughout the blink.
- Load while busy: during BLINK, load codop = F, addA = F, addB_LMM = F, addC = F -> ignored; after STEADY the display is still A,3,C,5 and LEDR = 18'h05C3A.
- Result and page toggle:
  - result_valid with result = 16'hBEEF in STEADY -> LEDG[0] = 1.
  - page_key low for 5 cycles -> HEX3..HEX0 = B,E,E,F, HEX4 = 'r', LEDG[0] = 0, LEDG[7] = 1, with exactly one toggle.
  - A second press returns to INSTR with HEX4 = 'I'.
- Reset and simultaneous events:
  - Reset asserted at cycle 6 of BLINK -> all outputs at reset values on the next edge.
  - Then load and result_valid in the same cycle -> both captured, verified via both pages after STEADY.
  - A page_key press during BLINK -> page unchanged after STEADY.
